// File: rtl/seg7_pkg.sv
// Seven-segment encodings (active-high, {g,f,e,d,c,b,a}) shared by display blocks.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
    unique case (nibble)
      4'h0: seg7_encode = SEG_0;
      4'h1: seg7_encode = SEG_1;
      4'h2: seg7_encode = SEG_2;
      4'h3: seg7_encode = SEG_3;
      4'h4: seg7_encode = SEG_4;
      4'h5: seg7_encode = SEG_5;
      4'h6: seg7_encode = SEG_6;
      4'h7: seg7_encode = SEG_7;
      4'h8: seg7_encode = SEG_8;
      4'h9: seg7_encode = SEG_9;
      4'hA: seg7_encode = SEG_A;
      4'hB: seg7_encode = SEG_B;
      4'hC: seg7_encode = SEG_C;
      4'hD: seg7_encode = SEG_D;
      4'hE: seg7_encode = SEG_E;
      default: seg7_encode = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb seg_o = seg7_encode(nibble_i);

endmodule

// File: rtl/hex_display_scanner.sv
// Double-buffered, time-multiplexed hex display driver with blank-slot anti-ghosting
// and optional leading-zero suppression.
module hex_display_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned CNT_W       = 24,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  blank_lz,
  output logic [6:0]            led_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_start
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DW   = 4 * DIGITS;
  localparam logic [6:0]        LedPol = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] EnPol  = {DIGITS{ACTIVE_LOW}};

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DW-1:0]     disp_q, disp_d, pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic [6:0]        led_q, led_d;
  logic [DIGITS-1:0] en_q, en_d;
  logic              fs_q, fs_d;

  logic              slot_wrap, frame_wrap, lz_blank;
  logic [3:0]        cur_nibble;
  logic [6:0]        cur_seg;
  logic [DIGITS-1:0] zero_up;

  assign slot_wrap  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign frame_wrap = slot_wrap && (idx_q == IdxW'(DIGITS - 1));
  assign cur_nibble = disp_q[{idx_q, 2'b00} +: 4];

  // zero_up[i]: nibbles i..DIGITS-1 of the displayed word are all zero
  always_comb begin
    zero_up = '0;
    zero_up[DIGITS-1] = (disp_q[DW-1 -: 4] == 4'h0);
    for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
      zero_up[i] = zero_up[i+1] && (disp_q[4*i +: 4] == 4'h0);
    end
  end

  assign lz_blank = blank_lz && (idx_q != '0) && zero_up[idx_q];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (cur_nibble),
    .seg_o    (cur_seg)
  );

  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    fs_d        = 1'b0;

    if (slot_wrap) begin
      cnt_d = '0;
      idx_d = frame_wrap ? '0 : idx_q + IdxW'(1);
    end

    if (data_valid && !pend_full_q) begin
      pend_d      = data_in;
      pend_full_d = 1'b1;
    end

    if (frame_wrap) begin
      fs_d = 1'b1;
      if (pend_full_q) begin
        disp_d      = pend_q;
        pend_full_d = 1'b0;
      end
    end

    // Blank for one cycle whenever the digit changes so segments never ghost across digits
    if (slot_wrap) begin
      en_d  = '0;
      led_d = SEG_BLANK;
    end else begin
      en_d  = DIGITS'(1) << idx_q;
      led_d = lz_blank ? SEG_BLANK : cur_seg;
    end
    en_d  = en_d ^ EnPol;
    led_d = led_d ^ LedPol;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      led_q       <= LedPol;
      en_q        <= EnPol;
      fs_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      led_q       <= led_d;
      en_q        <= en_d;
      fs_q        <= fs_d;
    end
  end

  assign data_ready  = !pend_full_q;
  assign led_out     = led_q;
  assign digit_en    = en_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: directed scenarios plus random traffic against a
// time-based reference model; an active-low twin shares all inputs.
module tb_hex_display_scanner;

  localparam int unsigned D = 4;
  localparam int unsigned R = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        blank_lz = 1'b0;
  logic        data_ready, frame_start, data_ready_n, frame_start_n;
  logic [6:0]  led_out, led_out_n;
  logic [3:0]  digit_en, digit_en_n;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state
  int unsigned c = 0;
  logic [15:0] shown = '0;
  logic [15:0] m_pend = '0;
  logic        m_full = 1'b0;
  logic [6:0]  seg_tab [16];

  always #5 clk = ~clk;

  hex_display_scanner #(.DIGITS(D), .REFRESH_DIV(R), .CNT_W(8), .ACTIVE_LOW(1'b0)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .blank_lz    (blank_lz),
    .led_out     (led_out),
    .digit_en    (digit_en),
    .frame_start (frame_start)
  );

  hex_display_scanner #(.DIGITS(D), .REFRESH_DIV(R), .CNT_W(8), .ACTIVE_LOW(1'b1)) u_dut_n (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready_n),
    .blank_lz    (blank_lz),
    .led_out     (led_out_n),
    .digit_en    (digit_en_n),
    .frame_start (frame_start_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_led", 32'(led_out), 32'h00);
    check("rst_en", 32'(digit_en), 32'h0);
    check("rst_fs", 32'(frame_start), 32'h0);
    check("rst_ready", 32'(data_ready), 32'h1);
    check("rst_led_n", 32'(led_out_n), 32'h7F);
    check("rst_en_n", 32'(digit_en_n), 32'hF);
  endtask

  task automatic model_reset();
    c = 0; shown = '0; m_pend = '0; m_full = 1'b0;
  endtask

  // One clock: predict outputs from elapsed time and model state, then compare after the edge.
  task automatic tick();
    int unsigned slot, pos;
    logic [15:0] w;
    logic [6:0]  el;
    logic [3:0]  ee;
    logic        ef;
    pos  = c % R;
    slot = (c / R) % D;
    if (pos == R - 1) begin
      el = 7'h00;
      ee = 4'h0;
    end else begin
      ee = 4'(1 << slot);
      w  = shown >> (4 * slot);
      el = (blank_lz && slot > 0 && w == 16'h0) ? 7'h00 : seg_tab[w[3:0]];
    end
    ef = (c % (D * R)) == D * R - 1;
    if (data_valid && !m_full) begin
      m_pend = data_in;
      m_full = 1'b1;
    end else if (ef && m_full) begin
      shown  = m_pend;
      m_full = 1'b0;
    end
    c++;
    @(posedge clk);
    #1;
    check("led", 32'(led_out), 32'(el));
    check("en", 32'(digit_en), 32'(ee));
    check("fs", 32'(frame_start), 32'(ef));
    check("ready", 32'(data_ready), 32'(!m_full));
    check("led_n", 32'(led_out_n), 32'(~el & 7'h7F));
    check("en_n", 32'(digit_en_n), 32'(~ee & 4'hF));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Hold the word on the bus until it is taken (bounded), then drop valid.
  task automatic offer(input logic [15:0] word);
    int n;
    n = 0;
    data_in    = word;
    data_valid = 1'b1;
    while (!data_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("offer_timeout", 32'(data_ready), 32'h1);
    tick();
    data_valid = 1'b0;
    data_in    = 16'(($urandom));
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    #12;
    check_reset_outputs();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();

    // Idle: two frames of zeros
    ticks(32);

    // fp16 1.0 mid-frame
    ticks(5);
    offer(16'h3C00);
    ticks(40);

    // Leading-zero blanking on and off
    blank_lz = 1'b1;
    offer(16'h0005);
    ticks(36);
    blank_lz = 1'b0;
    ticks(16);

    // Back-to-back offers within one frame
    ticks(3);
    offer(16'h1111);
    offer(16'h2222);
    ticks(40);

    // Async reset with a word pending
    ticks(6);
    offer(16'hBEEF);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    check_reset_outputs();
    reset_n = 1'b1;
    model_reset();
    ticks(40);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      data_valid = ($urandom_range(0, 3) == 0);
      data_in    = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
